// File: rtl/current_pkg.sv
// Shared types and constants for the current display path.
package current_pkg;

    localparam int CUR_W    = 27;
    localparam int CUR_FRAC = 22;
    // Largest displayable magnitude, just under 3.0 A.
    localparam int CUR_MAX  = 3 * (2 ** CUR_FRAC) - 1;

    typedef enum logic [1:0] {
        ACCUM,
        SCALE,
        SAT
    } state_t;

    typedef logic signed [CUR_W-1:0] cur_t;

endpackage

// File: rtl/sat_scale.sv
// Signed multiply by a constant gain, clamped to +/-CUR_MAX, held in a register
// that only loads on request. Shared with the power-path stage.
module sat_scale
    import current_pkg::*;
#(
    parameter int IN_W   = 12,
    parameter int GAIN_W = 20,
    parameter int GAIN   = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic signed [IN_W-1:0] din,
    output cur_t                   result,
    output logic                   sat_hit
);

    localparam int PROD_W = IN_W + GAIN_W;
    // Compare in a width that holds both the product and the clamp limits.
    localparam int EXT_W  = (PROD_W > CUR_W) ? PROD_W : CUR_W + 1;

    localparam logic signed [GAIN_W-1:0] GAIN_S = GAIN_W'(GAIN);
    localparam logic signed [EXT_W-1:0]  MAX_E  = EXT_W'(CUR_MAX);
    localparam logic signed [EXT_W-1:0]  MIN_E  = -MAX_E;

    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  prod_e;
    cur_t                     result_d;
    cur_t                     result_q;

    always_comb begin
        prod     = PROD_W'(din) * PROD_W'(GAIN_S);
        prod_e   = EXT_W'(prod);
        sat_hit  = 1'b0;
        result_d = result_q;
        if (load) begin
            if (prod_e > MAX_E) begin
                result_d = cur_t'(CUR_MAX);
                sat_hit  = 1'b1;
            end else if (prod_e < MIN_E) begin
                result_d = cur_t'(-CUR_MAX);
                sat_hit  = 1'b1;
            end else begin
                result_d = prod_e[CUR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) result_q <= '0;
        else       result_q <= result_d;
    end

    assign result = result_q;

endmodule

// File: rtl/current_averager.sv
// Averages signed ADC current codes over 2**LOG2_N samples, scales to Q5.22 amps,
// saturates, and holds the result between window boundaries.
module current_averager
    import current_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int LOG2_N   = 8,
    parameter int GAIN_W   = 20,
    parameter int GAIN     = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       clip_clear,
    output cur_t                       current,
    output logic                       current_valid,
    output logic                       clipped
);

    localparam int ACC_W = SAMPLE_W + LOG2_N;

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [ACC_W-1:0]    sum_q, sum_d;
    logic signed [SAMPLE_W-1:0] avg_q, avg_d;
    logic [LOG2_N-1:0]          cnt_q, cnt_d;
    logic                       ready_q, ready_d;
    logic                       valid_q, valid_d;
    logic                       clipped_q, clipped_d;

    logic xfer;
    logic load;
    logic sat_hit;

    assign xfer = sample_valid && ready_q;
    assign load = (state_q == SAT);

    // NOTE: every _d takes a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        avg_d     = avg_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        clipped_d = (load && sat_hit) || (clipped_q && !clip_clear);

        unique case (state_q)
            ACCUM: begin
                if (xfer) begin
                    if (&cnt_q) begin
                        sum_d   = acc_q + ACC_W'(sample);
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = SCALE;
                    end else begin
                        acc_d = acc_q + ACC_W'(sample);
                        cnt_d = cnt_q + LOG2_N'(1);
                    end
                end
            end
            SCALE: begin
                // Arithmetic shift floors toward -inf, so a sum of -1 averages to -1.
                avg_d   = SAMPLE_W'(sum_q >>> LOG2_N);
                state_d = SAT;
            end
            SAT: begin
                valid_d = 1'b1;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase

        ready_d = (state_d == ACCUM);
    end

    // NOTE: datapath registers are reset as well, so an aborted window leaves no stale sum behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            sum_q     <= '0;
            avg_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            clipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            avg_q     <= avg_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            clipped_q <= clipped_d;
        end
    end

    sat_scale #(
        .IN_W   (SAMPLE_W),
        .GAIN_W (GAIN_W),
        .GAIN   (GAIN)
    ) u_sat_scale (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (avg_q),
        .result  (current),
        .sat_hit (sat_hit)
    );

    assign sample_ready  = ready_q;
    assign current_valid = valid_q;
    assign clipped       = clipped_q;

endmodule

// File: tb/tb_current_averager.sv
// Scoreboard bench: two averagers (default gain and gain 8192) share one stimulus
// stream; a window-level reference model predicts every update and the handshake.
module tb_current_averager;
    import current_pkg::*;

    localparam int N = 256;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_valid;
    logic                clip_clear;
    logic signed [11:0]  sample;

    cur_t cur_o [2];
    logic vld_o [2];
    logic clp_o [2];
    logic rdy_o [2];

    always #5 clk = ~clk;

    current_averager u_dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_ready  (rdy_o[0]),
        .sample        (sample),
        .clip_clear    (clip_clear),
        .current       (cur_o[0]),
        .current_valid (vld_o[0]),
        .clipped       (clp_o[0])
    );

    current_averager #(.GAIN(8192)) u_dut_hi (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_ready  (rdy_o[1]),
        .sample        (sample),
        .clip_clear    (clip_clear),
        .current       (cur_o[1]),
        .current_valid (vld_o[1]),
        .clipped       (clp_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state, advanced once per rising edge by the driver.
    int     gains [2] = '{4096, 8192};
    int     exp_q0 [$];
    int     exp_q1 [$];
    int     held [2]  = '{0, 0};
    bit     m_clip [2] = '{0, 0};
    bit     pend [2]  = '{0, 0};
    longint m_sum     = 0;
    int     m_cnt     = 0;
    int     m_blank   = 0;
    int     m_sat_cd  = 0;
    bit     ready_exp = 1'b1;
    bit     exp_pulse = 1'b0;
    bit     last_xfer = 1'b0;

    function automatic void window_result(input longint sum, input int gain,
                                          output int cur, output bit sat);
        longint avg;
        longint p;
        avg = sum / N;
        if ((sum % N) != 0 && sum < 0) avg = avg - 1;
        p   = avg * gain;
        sat = 1'b1;
        if (p > CUR_MAX)       cur = CUR_MAX;
        else if (p < -CUR_MAX) cur = -CUR_MAX;
        else begin
            cur = int'(p);
            sat = 1'b0;
        end
    endfunction

    task automatic model_edge(input bit v, input logic signed [11:0] s, input bit clr, input bit rst);
        bit xfer;
        int c;
        bit st;
        last_xfer = 1'b0;
        exp_pulse = 1'b0;
        if (rst) begin
            m_sum = 0; m_cnt = 0; m_blank = 0; m_sat_cd = 0;
            ready_exp = 1'b1;
            exp_q0.delete();
            exp_q1.delete();
            for (int i = 0; i < 2; i++) begin
                held[i] = 0; m_clip[i] = 1'b0; pend[i] = 1'b0;
            end
        end else begin
            xfer = v && ready_exp;
            if (m_sat_cd > 0) begin
                m_sat_cd--;
                if (m_sat_cd == 0) exp_pulse = 1'b1;
            end
            for (int i = 0; i < 2; i++)
                m_clip[i] = (exp_pulse && pend[i]) || (m_clip[i] && !clr);
            if (m_blank > 0) m_blank--;
            if (xfer) begin
                last_xfer = 1'b1;
                m_sum += s;
                m_cnt++;
                if (m_cnt == N) begin
                    for (int i = 0; i < 2; i++) begin
                        window_result(m_sum, gains[i], c, st);
                        pend[i] = st;
                        if (i == 0) exp_q0.push_back(c);
                        else        exp_q1.push_back(c);
                    end
                    m_sat_cd = 2;
                    m_blank  = 2;
                    m_sum    = 0;
                    m_cnt    = 0;
                end
            end
            ready_exp = (m_blank == 0);
        end
    endtask

    // Monitor: pops the scoreboard on each update pulse, otherwise checks the hold.
    always @(negedge clk) begin
        int e;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("sample_ready[%0d]", i), rdy_o[i], ready_exp);
            check($sformatf("current_valid[%0d]", i), vld_o[i], exp_pulse);
            check($sformatf("clipped[%0d]", i), clp_o[i], m_clip[i]);
            if (vld_o[i]) begin
                int qs;
                qs = (i == 0) ? exp_q0.size() : exp_q1.size();
                check($sformatf("pulse_has_expect[%0d]", i), qs > 0, 1);
                if (qs > 0) begin
                    e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("current_update[%0d]", i), cur_o[i], e);
                    held[i] = e;
                end
            end else begin
                check($sformatf("current_hold[%0d]", i), cur_o[i], held[i]);
            end
        end
    end

    task automatic cycle(input bit v, input logic signed [11:0] s, input bit clr, input bit rst);
        sample_valid = v;
        sample       = s;
        clip_clear   = clr;
        reset        = rst;
        @(posedge clk);
        model_edge(v, s, clr, rst);
        @(negedge clk);
    endtask

    task automatic feed(input int n, input int val, input bit rnd, input int gap_pct, input bit clr_rnd);
        for (int k = 0; k < n; k++) begin
            logic signed [11:0] s;
            int tries;
            bit v;
            bit c;
            tries = 0;
            s = rnd ? 12'($urandom_range(4095)) : 12'(val);
            do begin
                v = ($urandom_range(99) >= gap_pct);
                c = clr_rnd && ($urandom_range(15) == 0);
                cycle(v, s, c, 1'b0);
                tries++;
                if (tries > 1000) begin
                    $display("FAIL feed_timeout: got %0d tries, expected at most 1000", tries);
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
                    $fatal(1, "sample never accepted");
                end
            end while (!last_xfer);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 12'sd0, 1'b0, 1'b0);
    endtask

    initial begin
        sample_valid = 1'b0;
        sample       = '0;
        clip_clear   = 1'b0;
        reset        = 1'b1;
        cycle(1'b0, 12'sd0, 1'b0, 1'b1);
        cycle(1'b0, 12'sd0, 1'b0, 1'b1);
        idle(2);

        feed(N, 1024, 1'b0, 0, 1'b0);   // 1.0 A
        idle(4);
        feed(N, -512, 1'b0, 0, 1'b0);   // -0.5 A
        idle(3);
        feed(N - 1, 0, 1'b0, 0, 1'b0);  // floor(-1/256) = -1
        feed(1, -1, 1'b0, 0, 1'b0);
        idle(3);

        feed(N, 1600, 1'b0, 0, 1'b0);   // saturates at gain 8192
        idle(3);
        feed(N, 0, 1'b0, 0, 1'b0);      // clipped stays set
        idle(3);
        cycle(1'b0, 12'sd0, 1'b1, 1'b0);
        idle(2);

        feed(N, 300, 1'b0, 50, 1'b0);   // gapped stream
        idle(3);

        feed(100, 2047, 1'b0, 0, 1'b0); // aborted window
        cycle(1'b0, 12'sd0, 1'b0, 1'b1);
        idle(2);
        feed(N, 1024, 1'b0, 0, 1'b0);
        idle(3);

        // clip_clear on the same edge as a saturating result: set wins.
        feed(N, 1600, 1'b0, 0, 1'b0);
        cycle(1'b0, 12'sd0, 1'b0, 1'b0);
        cycle(1'b0, 12'sd0, 1'b1, 1'b0);
        idle(3);

        for (int w = 0; w < 3; w++) begin
            feed(N, 0, 1'b1, 30, 1'b1);
        end
        idle(5);

        check("leftover_expect[0]", exp_q0.size(), 0);
        check("leftover_expect[1]", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
